wr_b_fmap: RTL and testbench
============================

Name: wr_b_fmap

Overview:
Generalised successor of the pooled-row BRAM writer. It accepts one row of OX features, tagged with channel and row index, through a valid/ready handshake. It writes the row into a byte-lane BRAM of B_COL_NUM lanes at any lane alignment, one word per cycle, with per-lane write enables. It sits between any conv/pool row producer and its output feature-map BRAM, and adds index range checking and back-pressure.

Parameters:
OCH, 6, output channels
OY, 14, rows per channel
OX, 14, features per row (>= B_COL_NUM)
O_F_BW, 8, feature width in bits
B_COL_NUM, 4, BRAM byte lanes (power of 2, >= 2)
B_DATA_W, B_COL_NUM*O_F_BW, BRAM word width (derived localparam)
B_ADDR_W, $clog2(OCH*OY*OX/B_COL_NUM), BRAM address width (derived localparam)

Ports:
clk  in  1  clock
areset_n  in  1  asynchronous active-low reset
i_valid  in  1  row request valid
o_ready  out  1  block can accept a row
i_och_idx  in  $clog2(OCH)  channel index
i_oy_idx  in  $clog2(OY)  row index
i_ox_fmap  in  OX*O_F_BW  row data; feature 0 in the LSBs
o_busy  out  1  row in progress
o_done  out  1  one-cycle pulse after the last beat
o_idx_err  out  1  sticky: out-of-range index received
b_o_addr  out  B_ADDR_W  BRAM word address
b_o_ce  out  1  BRAM enable; high on write beats only
b_o_byte_we  out  B_COL_NUM  per-lane write enable
b_o_d  out  B_DATA_W  BRAM write data

Behaviour:
- Reset (async assert, sync release): FSM in IDLE. All outputs 0 except o_ready=1.
- Handshake: a row is accepted on a rising edge where i_valid and o_ready are both high. At that edge the block registers the row, base = och*OY*OX + oy*OX (full-width product, no truncation), off = base % B_COL_NUM, and beats = ceil((off+OX)/B_COL_NUM).
- o_ready=1 only in IDLE.
- FSM states:
  - IDLE: on accept with valid indices -> WRITE. On accept with och>=OCH or oy>=OY -> set o_idx_err, stay in IDLE, no BRAM activity.
  - WRITE: emits one beat per cycle; after `beats` beats -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- Write outputs are registered. Beat j appears on b_o_* in cycle j+1 after the accept edge. Addresses run base/B_COL_NUM + j.
- Lane l of beat j carries feature k = j*B_COL_NUM + l - off.
- Byte enable for lane l is high iff 0 <= k < OX. The first beat masks lanes below off; the last beat masks lanes above (off+OX-1)%B_COL_NUM. Masked lanes drive 0.
- b_o_ce = OR of b_o_byte_we.
- o_busy is high in WRITE and DONE.
- Throughput: beats+2 cycles per row. Back-to-back rows are accepted on the IDLE cycle following DONE.
- i_valid while busy is ignored; the producer holds it until accepted. This is not an error.
- o_idx_err clears only on reset.
- Reset mid-row aborts immediately. Partial writes already issued remain in BRAM.
- Input data is shifted down by B_COL_NUM features per beat. No read-modify-write is performed, and neighbouring rows' lanes are never touched.

Optional Feature:
Macro WR_B_FMAP_RELU_EN.
- Defined: each feature is treated as two's-complement and clamped to 0 if negative, at capture, before lane placement. Adds no latency.
- Undefined: features are written unmodified.

Decomposition:
- Shared package `lenet_pkg`: B_COL_NUM, O_F_BW, the OCH/OY/OX defaults per layer, a clog2 helper, and an FSM state encoding typedef (IDLE/WRITE/DONE).
- One natural sub-module, `wr_b_lane_mask`: combinational generator of the first/last-beat byte mask from (off, beat index, beats, OX).

Test Plan:
1. Defaults; och=0, oy=0; features 0x01..0x0E -> 4 beats at addr 0,1,2,3; masks 1111,1111,1111,0011; beat0 d=0x04030201; o_done one cycle after beat 3.
2. och=0, oy=1 (base 14, off 2) -> addr 3..6; masks 1100,1111,1111,1111; beat0 d upper lanes = 0x02,0x01; lower lanes 0.
3. OX=13; och=0, oy=1 (base 13, off 1) -> addr 3..6; masks 1110,1111,1111,0011.
4. och=5, oy=13 -> base 1162; addr 290..293; last addr = 293, no overflow.
5. i_valid with och=6 -> o_idx_err=1 next cycle; b_o_ce stays 0; o_ready stays 1. Then issue a valid row -> writes normally and o_idx_err stays 1.
6. Back-to-back requests with i_valid held high -> second row accepted exactly beats+2 cycles after the first. Then assert areset_n=0 mid-beat 1 -> all outputs 0 and o_ready=1 immediately. With WR_B_FMAP_RELU_EN, feature 0x80 is written as 0x00.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator definitions: BRAM lane geometry, per-layer
// feature-map sizes, the row-writer FSM state encoding and a clog2 helper
// usable in constant expressions.
package lenet_pkg;

    localparam int LNT_B_COL_NUM = 4;
    localparam int LNT_O_F_BW    = 8;

    // conv1 output
    localparam int C1_OCH = 6;
    localparam int C1_OY  = 28;
    localparam int C1_OX  = 28;
    // pool1 output
    localparam int P1_OCH = 6;
    localparam int P1_OY  = 14;
    localparam int P1_OX  = 14;
    // conv2 output
    localparam int C2_OCH = 16;
    localparam int C2_OY  = 10;
    localparam int C2_OX  = 10;
    // pool2 output
    localparam int P2_OCH = 16;
    localparam int P2_OY  = 5;
    localparam int P2_OX  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    // Ceiling log2, same result as $clog2 for positive arguments.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wr_b_fmap_if.sv
// Row request channel of the feature-map BRAM writer: one row of OX
// features plus its channel/row index, transferred on valid & ready.
interface wr_b_fmap_if #(
    parameter int OCH    = lenet_pkg::P1_OCH,
    parameter int OY     = lenet_pkg::P1_OY,
    parameter int OX     = lenet_pkg::P1_OX,
    parameter int O_F_BW = lenet_pkg::LNT_O_F_BW
);
    localparam int OCH_W = lenet_pkg::clog2(OCH);
    localparam int OY_W  = lenet_pkg::clog2(OY);

    logic                  i_valid;
    logic                  o_ready;
    logic [OCH_W-1:0]      i_och_idx;
    logic [OY_W-1:0]       i_oy_idx;
    logic [OX*O_F_BW-1:0]  i_ox_fmap;

    modport master (
        output i_valid,
        output i_och_idx,
        output i_oy_idx,
        output i_ox_fmap,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_och_idx,
        input  i_oy_idx,
        input  i_ox_fmap,
        output o_ready
    );
endinterface

// File: rtl/wr_b_lane_mask.sv
// Byte-lane write mask for one beat of a row written at lane offset off_i.
// Only the first beat (lanes below the offset) and the last beat (lanes past
// the row's final feature) are partial; middle beats are all ones.
module wr_b_lane_mask #(
    parameter int B_COL_NUM = 4,
    parameter int OX        = 14,
    parameter int OFF_W     = 2,
    parameter int BEAT_W    = 3
) (
    input  logic [OFF_W-1:0]     off_i,
    input  logic [BEAT_W-1:0]    beat_idx_i,
    input  logic [BEAT_W-1:0]    beats_i,
    output logic [B_COL_NUM-1:0] mask_o
);
    // Lane of the last feature relative to the offset, modulo the lane count.
    localparam int LAST_REM = (OX - 1) % B_COL_NUM;

    logic [OFF_W-1:0]     last_lane_s;
    logic [B_COL_NUM-1:0] lo_ok_s;
    logic [B_COL_NUM-1:0] hi_ok_s;

    // Per-lane lower/upper bound test; wrap of last_lane_s is the modulo.
    always_comb begin
        last_lane_s = off_i + OFF_W'(LAST_REM);
        lo_ok_s     = '0;
        hi_ok_s     = '0;
        mask_o      = '0;
        for (int l = 0; l < B_COL_NUM; l++) begin
            lo_ok_s[l] = (beat_idx_i != '0) || (OFF_W'(l) >= off_i);
            hi_ok_s[l] = (beat_idx_i != (beats_i - BEAT_W'(1))) || (OFF_W'(l) <= last_lane_s);
            mask_o[l]  = lo_ok_s[l] & hi_ok_s[l];
        end
    end
endmodule

// File: rtl/wr_b_fmap.sv
// Feature-map row writer: accepts a row of OX features on a valid/ready
// channel and streams it into a byte-lane BRAM, one word per cycle, at any
// lane alignment, with per-lane write enables and index range checking.
// Optional build macro WR_B_FMAP_RELU_EN clamps negative (two's-complement)
// features to zero as the row is captured.
module wr_b_fmap
    import lenet_pkg::*;
#(
    parameter  int OCH       = P1_OCH,
    parameter  int OY        = P1_OY,
    parameter  int OX        = P1_OX,
    parameter  int O_F_BW    = LNT_O_F_BW,
    parameter  int B_COL_NUM = LNT_B_COL_NUM,
    localparam int B_DATA_W  = B_COL_NUM * O_F_BW,
    localparam int B_ADDR_W  = clog2(OCH * OY * OX / B_COL_NUM)
) (
    input  logic                 clk,
    input  logic                 areset_n,
    wr_b_fmap_if.slave           req,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_idx_err,
    output logic [B_ADDR_W-1:0]  b_o_addr,
    output logic                 b_o_ce,
    output logic [B_COL_NUM-1:0] b_o_byte_we,
    output logic [B_DATA_W-1:0]  b_o_d
);
    localparam int OCH_W     = clog2(OCH);
    localparam int OY_W      = clog2(OY);
    localparam int OFF_W     = clog2(B_COL_NUM);
    localparam int BASE_W    = clog2(OCH * OY * OX) + 1;
    localparam int MAX_BEATS = (OX + 2 * B_COL_NUM - 2) / B_COL_NUM;
    localparam int BEAT_W    = clog2(MAX_BEATS + 1);
    localparam int ROW_W     = OX * O_F_BW;
    localparam int SH_W      = MAX_BEATS * B_DATA_W;

    wr_state_e             state_q;
    logic                  o_ready_q;
    logic                  o_busy_q;
    logic                  o_done_q;
    logic                  o_idx_err_q;
    logic [B_ADDR_W-1:0]   addr_q;
    logic                  ce_q;
    logic [B_COL_NUM-1:0]  we_q;
    logic [B_DATA_W-1:0]   d_q;
    logic [OFF_W-1:0]      off_q;
    logic [BEAT_W-1:0]     beats_q;
    logic [BEAT_W-1:0]     beat_q;     // index of the next beat to issue
    logic [SH_W-1:0]       shift_q;    // remaining lane-aligned data, next beat in LSBs

    logic                  accept_s;
    logic                  idx_ok_s;
    logic [BASE_W-1:0]     base_s;
    logic [OFF_W-1:0]      off_s;
    logic [BEAT_W-1:0]     beats_s;
    logic [ROW_W-1:0]      feat_s;
    logic [SH_W-1:0]       shift_s;
    logic [OFF_W-1:0]      mk_off_s;
    logic [BEAT_W-1:0]     mk_beat_s;
    logic [BEAT_W-1:0]     mk_beats_s;
    logic [B_COL_NUM-1:0]  mask_s;
    logic [B_DATA_W-1:0]   raw_s;
    logic [B_DATA_W-1:0]   beat_d_s;

    // Feature conditioning at capture (optional ReLU clamp).
    always_comb begin
        feat_s = req.i_ox_fmap;
`ifdef WR_B_FMAP_RELU_EN
        for (int k = 0; k < OX; k++) begin
            feat_s[k*O_F_BW +: O_F_BW] = req.i_ox_fmap[k*O_F_BW + O_F_BW - 1] ?
                                         {O_F_BW{1'b0}} : req.i_ox_fmap[k*O_F_BW +: O_F_BW];
        end
`endif
    end

    // Request decode: accept, index check, base address, lane offset, beat count.
    always_comb begin
        accept_s = req.i_valid & o_ready_q;
        idx_ok_s = ({1'b0, req.i_och_idx} < (OCH_W+1)'(OCH)) &&
                   ({1'b0, req.i_oy_idx}  < (OY_W+1)'(OY));
        base_s   = BASE_W'(req.i_och_idx) * BASE_W'(OY * OX) +
                   BASE_W'(req.i_oy_idx)  * BASE_W'(OX);
        off_s    = base_s[OFF_W-1:0];
        beats_s  = BEAT_W'((32'(off_s) + OX + B_COL_NUM - 1) / B_COL_NUM);
        // Place feature 0 at lane `off` of beat 0; zeros fill the lanes below it.
        shift_s  = {{(SH_W-ROW_W){1'b0}}, feat_s} << (32'(off_s) * O_F_BW);
    end

    // Select the beat being generated: beat 0 of a new row in IDLE, else the running row.
    always_comb begin
        if (state_q == ST_IDLE) begin
            mk_off_s   = off_s;
            mk_beat_s  = '0;
            mk_beats_s = beats_s;
            raw_s      = shift_s[B_DATA_W-1:0];
        end else begin
            mk_off_s   = off_q;
            mk_beat_s  = beat_q;
            mk_beats_s = beats_q;
            raw_s      = shift_q[B_DATA_W-1:0];
        end
    end

    wr_b_lane_mask #(
        .B_COL_NUM (B_COL_NUM),
        .OX        (OX),
        .OFF_W     (OFF_W),
        .BEAT_W    (BEAT_W)
    ) u_lane_mask (
        .off_i      (mk_off_s),
        .beat_idx_i (mk_beat_s),
        .beats_i    (mk_beats_s),
        .mask_o     (mask_s)
    );

    // Masked lanes drive zero on the BRAM data bus.
    always_comb begin
        beat_d_s = '0;
        for (int l = 0; l < B_COL_NUM; l++) begin
            beat_d_s[l*O_F_BW +: O_F_BW] = mask_s[l] ? raw_s[l*O_F_BW +: O_F_BW] : {O_F_BW{1'b0}};
        end
    end

    // Row FSM with registered handshake, status and BRAM write outputs.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= ST_IDLE;
            o_ready_q   <= 1'b1;
            o_busy_q    <= 1'b0;
            o_done_q    <= 1'b0;
            o_idx_err_q <= 1'b0;
            addr_q      <= '0;
            ce_q        <= 1'b0;
            we_q        <= '0;
            d_q         <= '0;
            off_q       <= '0;
            beats_q     <= '0;
            beat_q      <= '0;
            shift_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    o_done_q <= 1'b0;
                    ce_q     <= 1'b0;
                    we_q     <= '0;
                    d_q      <= '0;
                    addr_q   <= '0;
                    if (accept_s && idx_ok_s) begin
                        state_q   <= ST_WRITE;
                        o_ready_q <= 1'b0;
                        o_busy_q  <= 1'b1;
                        off_q     <= off_s;
                        beats_q   <= beats_s;
                        beat_q    <= BEAT_W'(1);
                        shift_q   <= shift_s >> B_DATA_W;
                        addr_q    <= B_ADDR_W'(base_s >> OFF_W);
                        ce_q      <= |mask_s;
                        we_q      <= mask_s;
                        d_q       <= beat_d_s;
                    end else if (accept_s) begin
                        o_idx_err_q <= 1'b1;
                    end else begin
                        o_ready_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (beat_q == beats_q) begin
                        state_q  <= ST_DONE;
                        o_done_q <= 1'b1;
                        addr_q   <= '0;
                        ce_q     <= 1'b0;
                        we_q     <= '0;
                        d_q      <= '0;
                    end else begin
                        beat_q  <= beat_q + BEAT_W'(1);
                        shift_q <= shift_q >> B_DATA_W;
                        addr_q  <= addr_q + B_ADDR_W'(1);
                        ce_q    <= |mask_s;
                        we_q    <= mask_s;
                        d_q     <= beat_d_s;
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    o_done_q  <= 1'b0;
                    o_busy_q  <= 1'b0;
                    o_ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    o_ready_q <= 1'b1;
                    o_busy_q  <= 1'b0;
                    o_done_q  <= 1'b0;
                    addr_q    <= '0;
                    ce_q      <= 1'b0;
                    we_q      <= '0;
                    d_q       <= '0;
                end
            endcase
        end
    end

    assign req.o_ready = o_ready_q;
    assign o_busy      = o_busy_q;
    assign o_done      = o_done_q;
    assign o_idx_err   = o_idx_err_q;
    assign b_o_addr    = addr_q;
    assign b_o_ce      = ce_q;
    assign b_o_byte_we = we_q;
    assign b_o_d       = d_q;

endmodule

// File: tb/tb_wr_b_fmap.sv
// Bench for wr_b_fmap: a per-cycle expected-output queue built from the
// feature/lane placement rules, compared on every falling edge, plus
// directed literal checks for the notable rows and corner cases.
module tb_wr_b_fmap;
    import lenet_pkg::*;

    localparam int OCH      = 6;
    localparam int OY       = 14;
    localparam int OX       = 14;
    localparam int O_F_BW   = 8;
    localparam int B        = 4;
    localparam int B_DATA_W = B * O_F_BW;
    localparam int B_ADDR_W = 9;
    localparam int ROW_W    = OX * O_F_BW;

    typedef struct packed {
        logic [B_ADDR_W-1:0] addr;
        logic                ce;
        logic [B-1:0]        we;
        logic [B_DATA_W-1:0] d;
        logic                busy;
        logic                done;
        logic                ready;
    } exp_t;

    logic                clk = 1'b0;
    logic                areset_n;
    logic                o_busy;
    logic                o_done;
    logic                o_idx_err;
    logic [B_ADDR_W-1:0] b_o_addr;
    logic                b_o_ce;
    logic [B-1:0]        b_o_byte_we;
    logic [B_DATA_W-1:0] b_o_d;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t exp_q[$];
    bit   cur_ready = 1'b1;
    bit   m_err     = 1'b0;

    int                  m_beats;
    int                  m_addr [0:7];
    logic [B-1:0]        m_we   [0:7];
    logic [B_DATA_W-1:0] m_d    [0:7];

    wr_b_fmap_if #(.OCH(OCH), .OY(OY), .OX(OX), .O_F_BW(O_F_BW)) rif ();

    wr_b_fmap #(
        .OCH(OCH), .OY(OY), .OX(OX), .O_F_BW(O_F_BW), .B_COL_NUM(B)
    ) dut (
        .clk         (clk),
        .areset_n    (areset_n),
        .req         (rif),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_idx_err   (o_idx_err),
        .b_o_addr    (b_o_addr),
        .b_o_ce      (b_o_ce),
        .b_o_byte_we (b_o_byte_we),
        .b_o_d       (b_o_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Row placement from first principles: lane l of beat j holds feature j*B+l-off.
    function automatic void model_row(input int och, input int oy, input logic [ROW_W-1:0] fmap);
        int base, off, k;
        logic [O_F_BW-1:0] f;
        base    = och * OY * OX + oy * OX;
        off     = base % B;
        m_beats = (off + OX + B - 1) / B;
        for (int j = 0; j < m_beats; j++) begin
            m_addr[j] = base / B + j;
            m_we[j]   = '0;
            m_d[j]    = '0;
            for (int l = 0; l < B; l++) begin
                k = j * B + l - off;
                if (k >= 0 && k < OX) begin
                    f = fmap[k*O_F_BW +: O_F_BW];
`ifdef WR_B_FMAP_RELU_EN
                    if (f[O_F_BW-1]) f = '0;
`endif
                    m_we[j][l] = 1'b1;
                    m_d[j][l*O_F_BW +: O_F_BW] = f;
                end
            end
        end
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e       = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Model: on an accepted request queue the expected output of every following cycle.
    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            exp_q.delete();
            cur_ready = 1'b1;
            m_err     = 1'b0;
        end else if (rif.i_valid && cur_ready) begin
            if (int'(rif.i_och_idx) < OCH && int'(rif.i_oy_idx) < OY) begin
                exp_t e;
                model_row(int'(rif.i_och_idx), int'(rif.i_oy_idx), rif.i_ox_fmap);
                for (int j = 0; j < m_beats; j++) begin
                    e      = '0;
                    e.addr = B_ADDR_W'(m_addr[j]);
                    e.we   = m_we[j];
                    e.ce   = |m_we[j];
                    e.d    = m_d[j];
                    e.busy = 1'b1;
                    exp_q.push_back(e);
                end
                e      = '0;
                e.busy = 1'b1;
                e.done = 1'b1;
                exp_q.push_back(e);
            end else begin
                m_err = 1'b1;
            end
        end
    end

    // Compare process: every cycle out of reset, DUT outputs against the model.
    always @(negedge clk) begin
        if (areset_n === 1'b1) begin
            exp_t e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = idle_exp();
            cur_ready = e.ready;
            chk("cyc_addr",  64'(b_o_addr),    64'(e.addr));
            chk("cyc_ce",    64'(b_o_ce),      64'(e.ce));
            chk("cyc_we",    64'(b_o_byte_we), 64'(e.we));
            chk("cyc_d",     64'(b_o_d),       64'(e.d));
            chk("cyc_busy",  64'(o_busy),      64'(e.busy));
            chk("cyc_done",  64'(o_done),      64'(e.done));
            chk("cyc_ready", 64'(rif.o_ready), 64'(e.ready));
            chk("cyc_err",   64'(o_idx_err),   64'(m_err));
        end
    end

    // Present a row at a falling edge, hold it until accepted; return after the accept edge.
    task automatic send_row(input int och, input int oy, input logic [ROW_W-1:0] fmap,
                            input bit drop, output int acc);
        rif.i_valid   = 1'b1;
        rif.i_och_idx = 3'(och);
        rif.i_oy_idx  = 4'(oy);
        rif.i_ox_fmap = fmap;
        acc = -1;
        for (int t = 0; t < 64; t++) begin
            if (rif.o_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            chk("accept_timeout", 64'd0, 64'd1);
            rif.i_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            if (drop) rif.i_valid = 1'b0;
        end
    endtask

    function automatic logic [ROW_W-1:0] ramp();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < OX; k++) r[k*O_F_BW +: O_F_BW] = 8'(k + 1);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rnd_row();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < OX; k++) r[k*O_F_BW +: O_F_BW] = 8'($urandom);
        return r;
    endfunction

    initial begin
        int ca, cb, c;
        logic [ROW_W-1:0] fm;

        areset_n      = 1'b0;
        rif.i_valid   = 1'b0;
        rif.i_och_idx = '0;
        rif.i_oy_idx  = '0;
        rif.i_ox_fmap = '0;

        // Pin the model against hand-computed rows.
        model_row(0, 0, ramp());
        chk("pin1_beats", 64'(m_beats), 64'd4);
        chk("pin1_d0",    64'(m_d[0]),  64'h04030201);
        chk("pin1_we3",   64'(m_we[3]), 64'b0011);
        chk("pin1_addr3", 64'(m_addr[3]), 64'd3);
        model_row(0, 1, ramp());
        chk("pin2_addr0", 64'(m_addr[0]), 64'd3);
        chk("pin2_we0",   64'(m_we[0]), 64'b1100);
        chk("pin2_d0",    64'(m_d[0]),  64'h02010000);
        chk("pin2_we3",   64'(m_we[3]), 64'b1111);
        model_row(5, 13, ramp());
        chk("pin4_addr0", 64'(m_addr[0]), 64'd290);
        chk("pin4_addrN", 64'(m_addr[m_beats-1]), 64'd293);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(rif.o_ready), 64'd1);
        chk("rst_busy",  64'(o_busy), 64'd0);
        chk("rst_ce",    64'(b_o_ce), 64'd0);
        chk("rst_d",     64'(b_o_d), 64'd0);
        areset_n = 1'b1;
        @(negedge clk);

        // Aligned row.
        send_row(0, 0, ramp(), 1'b1, c);
        chk("t1_addr0", 64'(b_o_addr), 64'd0);
        chk("t1_we0",   64'(b_o_byte_we), 64'hF);
        chk("t1_d0",    64'(b_o_d), 64'h04030201);
        repeat (3) @(negedge clk);
        chk("t1_addr3", 64'(b_o_addr), 64'd3);
        chk("t1_we3",   64'(b_o_byte_we), 64'b0011);
        @(negedge clk);
        chk("t1_done",  64'(o_done), 64'd1);

        // Offset-2 row.
        send_row(0, 1, ramp(), 1'b1, c);
        chk("t2_addr0", 64'(b_o_addr), 64'd3);
        chk("t2_we0",   64'(b_o_byte_we), 64'b1100);
        chk("t2_d0",    64'(b_o_d), 64'h02010000);

        // Last row of the map.
        send_row(5, 13, rnd_row(), 1'b1, c);
        chk("t4_addr0", 64'(b_o_addr), 64'd290);
        repeat (3) @(negedge clk);
        chk("t4_addr3", 64'(b_o_addr), 64'd293);

        // Out-of-range channel, then a valid row.
        send_row(6, 0, rnd_row(), 1'b1, c);
        chk("t5_err",   64'(o_idx_err), 64'd1);
        chk("t5_ce",    64'(b_o_ce), 64'd0);
        chk("t5_ready", 64'(rif.o_ready), 64'd1);
        send_row(2, 7, rnd_row(), 1'b1, c);
        chk("t5_err_hold", 64'(o_idx_err), 64'd1);

        // Back-to-back with valid held high.
        send_row(0, 0, rnd_row(), 1'b0, ca);
        send_row(0, 2, rnd_row(), 1'b1, cb);
        chk("t6_spacing", 64'(cb - ca), 64'd6);

        // Feature clamp (or pass-through) of negative features.
        fm = ramp();
        fm[7:0]   = 8'h80;
        fm[23:16] = 8'hFF;
        send_row(0, 0, fm, 1'b1, c);
`ifdef WR_B_FMAP_RELU_EN
        chk("relu_lane0", 64'(b_o_d[7:0]),   64'h00);
        chk("relu_lane2", 64'(b_o_d[23:16]), 64'h00);
`else
        chk("relu_lane0", 64'(b_o_d[7:0]),   64'h80);
        chk("relu_lane2", 64'(b_o_d[23:16]), 64'hFF);
`endif

        // Randomized rows, including out-of-range indices and gaps.
        for (int r = 0; r < 80; r++) begin
            int gap;
            gap = $urandom_range(0, 3);
            send_row($urandom_range(0, 7), $urandom_range(0, 15), rnd_row(), gap != 0, c);
            repeat (gap) @(negedge clk);
        end
        rif.i_valid = 1'b0;

        // Reset in the middle of beat 1.
        send_row(3, 5, rnd_row(), 1'b1, c);
        @(posedge clk);
        #2;
        areset_n = 1'b0;
        #1;
        chk("mid_rst_ce",    64'(b_o_ce), 64'd0);
        chk("mid_rst_we",    64'(b_o_byte_we), 64'd0);
        chk("mid_rst_d",     64'(b_o_d), 64'd0);
        chk("mid_rst_addr",  64'(b_o_addr), 64'd0);
        chk("mid_rst_busy",  64'(o_busy), 64'd0);
        chk("mid_rst_done",  64'(o_done), 64'd0);
        chk("mid_rst_err",   64'(o_idx_err), 64'd0);
        chk("mid_rst_ready", 64'(rif.o_ready), 64'd1);
        @(negedge clk);
        areset_n = 1'b1;

        send_row(1, 9, rnd_row(), 1'b1, c);
        for (int t = 0; t < 64; t++) begin
            if (exp_q.size() == 0 && rif.o_ready === 1'b1) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
